// File: rtl/arb_puf_vote_sequencer.sv
// Challenge sequencer for the arbiter-PUF core: runs VOTE_N clear/launch/settle/sample
// rounds per accepted challenge and returns a majority-voted response plus instability mask.
module arb_puf_vote_sequencer #(
    parameter int CHAL_W        = 32,
    parameter int RESP_W        = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int VOTE_N        = 7
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CHAL_W-1:0] cmd_challenge,
    input  logic              abort,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_clear,
    output logic              puf_launch,
    input  logic [RESP_W-1:0] puf_response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_data,
    output logic [RESP_W-1:0] rsp_unstable,
    output logic              busy
);

    localparam int CW = $clog2(VOTE_N + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    generate
        if (VOTE_N < 1 || (VOTE_N % 2) == 0) begin : g_badVote
            $error("VOTE_N must be odd and at least 1");
        end
        if (SETTLE_CYCLES < 1) begin : g_badSettle
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, LOAD, CLEAR, LAUNCH, SETTLE, SAMPLE, DECIDE, OUTPUT
    } state_e;

    state_e            state_q, state_d;
    logic [CHAL_W-1:0] chalCap_q;
    logic [CHAL_W-1:0] pufChal_q;
    logic [SW-1:0]     settleCnt_q;
    logic [CW-1:0]     roundCnt_q;
    logic [CW-1:0]     voteCnt_q [RESP_W];
    logic [RESP_W-1:0] rspData_q;
    logic [RESP_W-1:0] rspUnstable_q;
    logic [CW-1:0]     roundNext;
    logic [RESP_W-1:0] decideData;
    logic [RESP_W-1:0] decideUnstable;

    assign roundNext = roundCnt_q + CW'(1);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over every other transition, including the OUTPUT handshake.
    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cmd_valid) state_d = LOAD;
                LOAD:    state_d = CLEAR;
                CLEAR:   state_d = LAUNCH;
                LAUNCH:  state_d = SETTLE;
                SETTLE:  if (settleCnt_q == '0) state_d = SAMPLE;
                SAMPLE:  state_d = (roundNext < CW'(VOTE_N)) ? CLEAR : DECIDE;
                DECIDE:  state_d = OUTPUT;
                OUTPUT:  if (rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        puf_clear  = 1'b0;
        puf_launch = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            CLEAR:   puf_clear  = 1'b1;
            LAUNCH:  puf_launch = 1'b1;
            OUTPUT:  rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        decideData     = '0;
        decideUnstable = '0;
        for (int i = 0; i < RESP_W; i++) begin
            decideData[i]     = (voteCnt_q[i] > CW'(VOTE_N / 2));
            decideUnstable[i] = (voteCnt_q[i] != '0) && (voteCnt_q[i] != CW'(VOTE_N));
        end
    end

    // The settle counter is loaded with S-1 so that SETTLE spans exactly S cycles.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            chalCap_q     <= '0;
            pufChal_q     <= '0;
            settleCnt_q   <= '0;
            roundCnt_q    <= '0;
            rspData_q     <= '0;
            rspUnstable_q <= '0;
            for (int i = 0; i < RESP_W; i++) voteCnt_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) chalCap_q <= cmd_challenge;
                LOAD: begin
                    pufChal_q  <= chalCap_q;
                    roundCnt_q <= '0;
                    for (int i = 0; i < RESP_W; i++) voteCnt_q[i] <= '0;
                end
                LAUNCH: settleCnt_q <= SW'(SETTLE_CYCLES - 1);
                SETTLE: if (settleCnt_q != '0) settleCnt_q <= settleCnt_q - SW'(1);
                SAMPLE: begin
                    roundCnt_q <= roundNext;
                    for (int i = 0; i < RESP_W; i++) begin
                        voteCnt_q[i] <= voteCnt_q[i] + CW'(puf_response[i]);
                    end
                end
                DECIDE: begin
                    rspData_q     <= decideData;
                    rspUnstable_q <= decideUnstable;
                end
                default: ;
            endcase
        end
    end

    assign puf_challenge = pufChal_q;
    assign rsp_data      = rspData_q;
    assign rsp_unstable  = rspUnstable_q;

endmodule

// File: tb/tb_arb_puf_vote_sequencer.sv
// Directed bench for arb_puf_vote_sequencer: a default-parameter instance checked through a
// response scoreboard, plus a SETTLE_CYCLES=1 / VOTE_N=1 instance for timing corner cases.
module tb_arb_puf_vote_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic        aCmdValid, aCmdReady, aAbort, aClear, aLaunch;
    logic        aRspValid, aRspReady, aBusy;
    logic [31:0] aChal, aPufChal;
    logic [3:0]  aResp, aRspData, aRspUnst;

    logic        bCmdValid, bCmdReady, bAbort, bClear, bLaunch;
    logic        bRspValid, bRspReady, bBusy;
    logic [31:0] bChal, bPufChal;
    logic [3:0]  bResp, bRspData, bRspUnst;

    int          nChecks = 0;
    int          nBad = 0;
    int          cyc, clrCnt, launchCnt, roundIdx;
    logic        prevClear;
    logic [3:0]  pat [8];
    logic [7:0]  sb [$];

    always #5 clk = ~clk;

    arb_puf_vote_sequencer dutA (
        .ACLK(clk), .ARESET(rst),
        .cmd_valid(aCmdValid), .cmd_ready(aCmdReady), .cmd_challenge(aChal),
        .abort(aAbort), .puf_challenge(aPufChal), .puf_clear(aClear),
        .puf_launch(aLaunch), .puf_response(aResp),
        .rsp_valid(aRspValid), .rsp_ready(aRspReady), .rsp_data(aRspData),
        .rsp_unstable(aRspUnst), .busy(aBusy)
    );

    arb_puf_vote_sequencer #(.SETTLE_CYCLES(1), .VOTE_N(1)) dutB (
        .ACLK(clk), .ARESET(rst),
        .cmd_valid(bCmdValid), .cmd_ready(bCmdReady), .cmd_challenge(bChal),
        .abort(bAbort), .puf_challenge(bPufChal), .puf_clear(bClear),
        .puf_launch(bLaunch), .puf_response(bResp),
        .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_data(bRspData),
        .rsp_unstable(bRspUnst), .busy(bBusy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] voteModel();
        logic [3:0] d, u;
        int         ones;
        d = '0;
        u = '0;
        for (int b = 0; b < 4; b++) begin
            ones = 0;
            for (int r = 0; r < 7; r++) ones += int'(pat[r][b]);
            d[b] = (ones >= 4);
            u[b] = (ones != 0) && (ones != 7);
        end
        return {d, u};
    endfunction

    task automatic setPatConst(input logic [3:0] v);
        for (int r = 0; r < 8; r++) pat[r] = v;
    endtask

    // Advance one cycle: score a handshake about to happen, then track clear/launch pulses
    // and present the next round's arbiter response.
    task automatic tick();
        logic [7:0] exp;
        if (aRspValid && aRspReady) begin
            checkOutput("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checkOutput("rsp_data_unstable", 32'({aRspData, aRspUnst}), 32'(exp));
            end
        end
        @(negedge clk);
        cyc++;
        if (aLaunch) begin
            launchCnt++;
            checkOutput("launch_after_clear", 32'(prevClear), 1);
        end
        prevClear = aClear;
        if (aClear) begin
            clrCnt++;
            aResp = pat[roundIdx];
            if (roundIdx < 7) roundIdx++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] chal, input bit expectRsp);
        int guard = 0;
        while (!aCmdReady && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("cmd_ready_before_cmd", 32'(aCmdReady), 1);
        aChal = chal;
        aCmdValid = 1'b1;
        if (expectRsp) sb.push_back(voteModel());
        cyc = 0;
        clrCnt = 0;
        launchCnt = 0;
        roundIdx = 0;
        prevClear = 1'b0;
        tick();
        aCmdValid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        int guard = 0;
        while (!aRspValid && guard < 300) begin
            tick();
            guard++;
        end
        checkOutput("rsp_valid_timeout", 32'(aRspValid), 1);
        lat = cyc;
    endtask

    task automatic finishRsp();
        aRspReady = 1'b1;
        tick();
        aRspReady = 1'b0;
        checkOutput("cmd_ready_after_rsp", 32'(aCmdReady), 1);
        checkOutput("rsp_valid_drop", 32'(aRspValid), 0);
        checkOutput("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic runSweep(input bit offWindow, output int launchCyc, output int validCyc);
        launchCyc = 0;
        validCyc = 0;
        bChal = offWindow ? 32'h0BAD_F00D : 32'hDEAD_BEEF;
        bCmdValid = 1'b1;
        for (int k = 1; k <= 20 && validCyc == 0; k++) begin
            @(negedge clk);
            bCmdValid = 1'b0;
            if (bLaunch) launchCyc = k;
            if (launchCyc > 0 && !offWindow && k == launchCyc + 2) bResp = 4'hF;
            else if (launchCyc > 0 && offWindow && (k == launchCyc + 1 || k == launchCyc + 3)) bResp = 4'hF;
            else bResp = 4'h0;
            if (bRspValid) validCyc = k;
        end
    endtask

    initial begin
        int   lat, bl, bv, launchSnap;
        logic sawValid;

        rst = 1'b1;
        aCmdValid = 1'b0; aChal = '0; aAbort = 1'b0; aResp = '0; aRspReady = 1'b0;
        bCmdValid = 1'b0; bChal = '0; bAbort = 1'b0; bResp = '0; bRspReady = 1'b0;
        cyc = 0; clrCnt = 0; launchCnt = 0; roundIdx = 0; prevClear = 1'b0;
        setPatConst(4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(aBusy), 0);
        checkOutput("rst_rsp_valid", 32'(aRspValid), 0);
        checkOutput("rst_clear", 32'(aClear), 0);
        checkOutput("rst_launch", 32'(aLaunch), 0);
        checkOutput("rst_puf_chal", aPufChal, 0);
        checkOutput("rst_rsp_data", 32'(aRspData), 0);
        checkOutput("rst_rsp_unst", 32'(aRspUnst), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", 32'(aCmdReady), 1);

        // Stable response held for every round
        setPatConst(4'b1011);
        applyStimulus(32'hA5A5_5A5A, 1'b1);
        waitValid(lat);
        checkOutput("t1_latency", 32'(lat), 80);
        checkOutput("t1_clears", 32'(clrCnt), 7);
        checkOutput("t1_launches", 32'(launchCnt), 7);
        checkOutput("t1_puf_chal", aPufChal, 32'hA5A5_5A5A);
        finishRsp();

        // Noisy bit 0: four ones, then three ones out of seven rounds
        for (int r = 0; r < 8; r++) pat[r] = (r % 2 == 0) ? 4'b0001 : 4'b0000;
        pat[6] = 4'b0001;
        applyStimulus(32'h1111_2222, 1'b1);
        waitValid(lat);
        finishRsp();
        pat[6] = 4'b0000;
        applyStimulus(32'h3333_4444, 1'b1);
        waitValid(lat);
        finishRsp();

        // Backpressure on the response port
        setPatConst(4'b0110);
        applyStimulus(32'h5555_6666, 1'b1);
        waitValid(lat);
        launchSnap = launchCnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("stall_rsp_data", 32'(aRspData), 32'h6);
            checkOutput("stall_cmd_ready", 32'(aCmdReady), 0);
            checkOutput("stall_no_launch", 32'(launchCnt), 32'(launchSnap));
        end
        finishRsp();
        setPatConst(4'b1100);
        applyStimulus(32'h7777_8888, 1'b1);
        waitValid(lat);
        checkOutput("t3b_latency", 32'(lat), 80);
        finishRsp();

        // Abort in SETTLE of round 3 (cycles 37..44)
        setPatConst(4'b1111);
        applyStimulus(32'h0C0F_FEE0, 1'b0);
        while (cyc < 40) tick();
        checkOutput("pre_abort_busy", 32'(aBusy), 1);
        aAbort = 1'b1;
        tick();
        aAbort = 1'b0;
        checkOutput("abort_idle", 32'(aCmdReady), 1);
        checkOutput("abort_busy", 32'(aBusy), 0);
        checkOutput("abort_chal_kept", aPufChal, 32'h0C0F_FEE0);
        sawValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (aRspValid) sawValid = 1'b1;
        end
        checkOutput("abort_no_rsp", 32'(sawValid), 0);
        for (int r = 0; r < 8; r++) pat[r] = (r < 5) ? 4'b1001 : 4'b0110;
        applyStimulus(32'h9999_AAAA, 1'b1);
        waitValid(lat);
        checkOutput("t4_latency", 32'(lat), 80);
        checkOutput("t4_clears", 32'(clrCnt), 7);
        finishRsp();

        // Reset during the clear pulse of round 5
        setPatConst(4'b1111);
        applyStimulus(32'h1234_5678, 1'b0);
        while (clrCnt < 6 && cyc < 200) tick();
        checkOutput("r5_clear_seen", 32'(aClear), 1);
        rst = 1'b1;
        #1;
        checkOutput("arst_clear", 32'(aClear), 0);
        checkOutput("arst_launch", 32'(aLaunch), 0);
        checkOutput("arst_busy", 32'(aBusy), 0);
        checkOutput("arst_rsp_valid", 32'(aRspValid), 0);
        checkOutput("arst_puf_chal", aPufChal, 0);
        checkOutput("arst_rsp_data", 32'(aRspData), 0);
        checkOutput("arst_rsp_unst", 32'(aRspUnst), 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("arst_cmd_ready", 32'(aCmdReady), 1);
        sawValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (aRspValid) sawValid = 1'b1;
        end
        checkOutput("arst_no_stale_rsp", 32'(sawValid), 0);

        // SETTLE_CYCLES=1, VOTE_N=1: response only counts in the cycle two after launch
        runSweep(1'b0, bl, bv);
        checkOutput("sweep_valid_cycle", 32'(bv), 7);
        checkOutput("sweep_launch_cycle", 32'(bl), 3);
        checkOutput("sweep_data", 32'(bRspData), 32'hF);
        checkOutput("sweep_unst", 32'(bRspUnst), 0);
        checkOutput("sweep_chal", bPufChal, 32'hDEAD_BEEF);
        bRspReady = 1'b1;
        @(negedge clk);
        bRspReady = 1'b0;
        checkOutput("sweep_cmd_ready", 32'(bCmdReady), 1);
        checkOutput("sweep_busy", 32'(bBusy), 0);
        runSweep(1'b1, bl, bv);
        checkOutput("sweep2_valid_cycle", 32'(bv), 7);
        checkOutput("sweep2_data", 32'(bRspData), 0);
        checkOutput("sweep2_unst", 32'(bRspUnst), 0);
        bRspReady = 1'b1;
        @(negedge clk);
        bRspReady = 1'b0;
        checkOutput("sweep2_cmd_ready", 32'(bCmdReady), 1);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
